// File: rtl/echo_detector.sv
// echo_detector: finds the first sonar echo after each ping on an 8-bit ADC stream.
// Tracks the idle DC baseline and reports time-of-flight and peak magnitude per listen window.
module echo_detector #(
  parameter int BASELINE_SHIFT = 4,
  parameter int BLANK_SAMPLES = 32,
  parameter int WINDOW_SAMPLES = 1024,
  parameter int TOF_W = 10
) (
  input logic clk,
  input logic reset,
  input logic sampleClk,
  input logic [7:0] sample,
  input logic start,
  input logic [7:0] threshold,
  output logic busy,
  output logic done,
  output logic echoFound,
  output logic [TOF_W-1:0] echoIndex,
  output logic [7:0] echoPeak,
  output logic [7:0] magnitude,
  output logic magValid
);
  localparam int AW = 8 + BASELINE_SHIFT;
  localparam logic [1:0] IDLE = 2'd0, BLANK = 2'd1, LISTEN = 2'd2;
  localparam logic [TOF_W-1:0] BLANK_LAST = TOF_W'(BLANK_SAMPLES - 1);
  localparam logic [TOF_W-1:0] WIN_LAST = TOF_W'(WINDOW_SAMPLES - 1);
  logic [1:0] state;
  logic sclk_q;
  logic [AW-1:0] acc, acc_next;
  logic [TOF_W-1:0] idx;
  logic [7:0] baseline, mag;
  logic [8:0] diff;
  logic ev;
  assign ev = sampleClk & ~sclk_q;
  assign baseline = acc[AW-1:BASELINE_SHIFT];
  assign diff = {1'b0, sample} - {1'b0, baseline};
  assign mag = diff[8] ? 8'(-diff) : diff[7:0];
  // acc stays within AW bits: acc - (acc>>SHIFT) + sample never exceeds 255<<SHIFT plus the fraction
  assign acc_next = acc + AW'(sample) - AW'(baseline);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sclk_q <= 1'b0;
      acc <= AW'(128) << BASELINE_SHIFT;
      idx <= '0;
      done <= 1'b0;
      echoFound <= 1'b0;
      echoIndex <= '0;
      echoPeak <= '0;
      magnitude <= '0;
      magValid <= 1'b0;
    end else begin
      sclk_q <= sampleClk;
      magValid <= ev;
      done <= 1'b0;
      if (ev) magnitude <= mag;
      if (ev && state == IDLE) acc <= acc_next;
      if (state == IDLE) begin
        if (start) begin
          echoFound <= 1'b0;
          echoIndex <= '0;
          echoPeak <= '0;
          idx <= '0;
          state <= (BLANK_SAMPLES == 0) ? LISTEN : BLANK;
        end
      end else if (ev) begin
        idx <= idx + 1'b1;
        if (state == BLANK) begin
          if (idx == BLANK_LAST) state <= LISTEN;
        end else begin
          if (!echoFound && mag > threshold) begin
            echoFound <= 1'b1;
            echoIndex <= idx;
            echoPeak <= mag;
          end else if (echoFound && mag > echoPeak) echoPeak <= mag;
          if (idx == WIN_LAST) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
      end
    end
endmodule
